demux1to8_4bit_reg: RTL and testbench
=====================================

Name: demux1to8_4bit_reg

Overview:
- Registered 1-to-8 demultiplexer: the distribution counterpart to the team's 8-to-1 4-bit selector.
- Accepts a stream of 4-bit words over a valid/ready handshake and steers each word into one of eight held output registers.
- Destination comes from an explicit 3-bit select or an internal auto-incrementing pointer.
- Tracks which channels are loaded, signals a completed frame when all eight are filled, and stalls until the frame is acknowledged.

Parameters:
- WIDTH, 4, data width of input word and each output channel.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- D  input  WIDTH  input data word
- S  input  3  explicit destination channel (used when auto=0)
- auto  input  1  1: destination = internal pointer ptr; 0: destination = S
- in_valid  input  1  D/S valid this cycle
- in_ready  output  1  block can accept a word this cycle
- clr  input  1  synchronous clear of loaded flags and pointer
- frame_ack  input  1  consumer acknowledges a full frame
- Q0..Q7  output  WIDTH each  held channel registers
- loaded  output  8  per-channel loaded flag, bit i for Qi
- frame_done  output  1  one-cycle pulse on entering FULL
- ptr  output  3  current auto pointer value

Behaviour:
- Clocking and reset:
  - Single clock domain (clk).
  - rst is asynchronous and active-high.
  - While rst is high: Q0..Q7=0, loaded=0, ptr=0, frame_done=0, state=EMPTY; in_ready reads 1 once rst deasserts.
- States: EMPTY (loaded==0), FILLING (some loaded bits set), FULL (loaded==8'hFF).
- in_ready = !clr && (state != FULL); combinational, from registered state only, no dependence on in_valid.
- Accept = in_valid && in_ready. The destination index is idx = auto ? ptr : S. On accept, next edge:
  - Q[idx] <= D.
  - loaded[idx] <= 1.
  - If auto=1, ptr <= ptr+1, wrapping 7->0 (3-bit modulo). If auto=0, ptr is unchanged.
- Latency:
  - Accepted word is visible on Q[idx] and loaded[idx] one cycle after the accept edge.
  - Other Qi hold their values.
- Overwrite: explicit-mode write to an already-loaded channel replaces Q data; loaded unchanged; no error.
- Transitions:
  - EMPTY -> FILLING on any accept that does not complete the set.
  - EMPTY/FILLING -> FULL when loaded | (1<<idx) == 8'hFF on the accept.
  - frame_done=1 for exactly the cycle after that edge (registered pulse).
  - FULL -> EMPTY on frame_ack: loaded <= 0, ptr <= 0. Q0..Q7 retain data.
  - frame_ack outside FULL is ignored.
- FULL stalls input (in_ready=0); in_valid held high is not lost and is accepted after the return to EMPTY.
- clr (any state):
  - next edge: loaded=0, ptr=0, state=EMPTY, Q retained.
  - Has priority over accept (in_ready forced low) and over frame_ack.
  - frame_done is not generated by clr.
- Mid-frame auto change: ptr keeps its value; switching auto 0->1 resumes from the current ptr.
- Reset mid-frame: immediate asynchronous return to reset values; a partial frame is discarded.
- Q outputs are direct register outputs (glitch-free, no combinational path from D).

Decomposition:
- Shared package demux_pkg:
  - typedef state_t {EMPTY, FILLING, FULL}.
  - Constants NUM_CH=8, SEL_W=3, ALL_LOADED=8'hFF.
- Optional sub-module demux_ptr: 3-bit wrap counter with inc/clear, also reusable by future scanners.
- Channel registers and flags stay in the top level.

Test Plan:
- Reset, then auto=1, stream D=1..8 with in_valid continuous:
  - Q0..Q7 = 1..8.
  - ptr wraps to 0.
  - loaded=8'hFF.
  - frame_done high exactly one cycle after 8th accept.
  - in_ready=0 thereafter.
- FULL with in_valid=1, D=4'hA, auto=1, held 3 cycles, then frame_ack:
  - no Q change while stalled.
  - loaded=0 and ptr=0 after ack.
  - next cycle accepts A into Q0.
- Explicit mode: S=5 D=3, then S=5 D=9, then S=2 D=4:
  - Q5=9, Q2=4.
  - loaded=8'b00100100.
  - ptr stays 0.
  - no frame_done.
- clr asserted together with in_valid on the 4th word of an auto frame:
  - the word is not written.
  - loaded=0, ptr=0.
  - Q0..Q2 retain values.
- Async rst pulsed mid-cycle during FILLING (loaded=8'h0F): outputs zero immediately, without waiting for a clk edge.
- Random valid gaps with auto=1 over 3 frames with ack: scoreboard checks each Qi against a model.
  - frame_done count = 3.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the registered 1-to-8 demultiplexer family.
package demux_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam logic [NUM_CH-1:0] ALL_LOADED = 8'hFF;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/demux_ptr.sv
// Wrapping channel pointer with increment and synchronous clear (clear wins).
module demux_ptr
  import demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [SEL_W-1:0] cnt_o
);

  logic [SEL_W-1:0] cnt_q;
  logic [SEL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/demux1to8_4bit_reg.sv
// Registered 1-to-8 demultiplexer: steers handshaked words into eight held
// channel registers, tracks loaded channels and stalls on a full frame.
module demux1to8_4bit_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic [SEL_W-1:0] S,
  input  logic             auto,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  input  logic             frame_ack,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic [WIDTH-1:0] Q4,
  output logic [WIDTH-1:0] Q5,
  output logic [WIDTH-1:0] Q6,
  output logic [WIDTH-1:0] Q7,
  output logic [NUM_CH-1:0] loaded,
  output logic             frame_done,
  output logic [SEL_W-1:0] ptr
);

  state_t            state_q;
  logic [WIDTH-1:0]  chan_q [NUM_CH];
  logic [NUM_CH-1:0] loaded_q;
  logic [NUM_CH-1:0] loaded_d;
  logic              frameDone_q;
  logic [SEL_W-1:0]  ptrVal;
  logic [SEL_W-1:0]  idx;
  logic              accept;
  logic              ackFull;

  assign in_ready = !clr && (state_q != FULL);
  assign accept   = in_valid && in_ready;
  assign ackFull  = (state_q == FULL) && frame_ack && !clr;
  assign idx      = auto ? ptrVal : S;
  assign loaded_d = loaded_q | (NUM_CH'(1) << idx);

  demux_ptr u_ptr (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (accept && auto),
    .clear_i (clr || ackFull),
    .cnt_o   (ptrVal)
  );

  // clr outranks the frame acknowledge, which in turn only matters in FULL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      loaded_q    <= '0;
      frameDone_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) chan_q[i] <= '0;
    end else begin
      frameDone_q <= 1'b0;
      if (clr || ackFull) begin
        state_q  <= EMPTY;
        loaded_q <= '0;
      end else if (accept) begin
        chan_q[idx] <= D;
        loaded_q    <= loaded_d;
        if (loaded_d == ALL_LOADED) begin
          state_q     <= FULL;
          frameDone_q <= 1'b1;
        end else begin
          state_q <= FILLING;
        end
      end
    end
  end

  assign Q0         = chan_q[0];
  assign Q1         = chan_q[1];
  assign Q2         = chan_q[2];
  assign Q3         = chan_q[3];
  assign Q4         = chan_q[4];
  assign Q5         = chan_q[5];
  assign Q6         = chan_q[6];
  assign Q7         = chan_q[7];
  assign loaded     = loaded_q;
  assign frame_done = frameDone_q;
  assign ptr        = ptrVal;

endmodule

// File: tb/tb_demux1to8_4bit_reg.sv
// Directed bench for demux1to8_4bit_reg with an inline model for the random-gap frames.
module tb_demux1to8_4bit_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] D;
  logic [2:0] S;
  logic       auto;
  logic       inValid;
  logic       inReady;
  logic       clr;
  logic       frameAck;
  logic [3:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
  logic [7:0] loaded;
  logic       frameDone;
  logic [2:0] ptr;
  logic [3:0] qOut [8];

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  demux1to8_4bit_reg #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .D          (D),
    .S          (S),
    .auto       (auto),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .clr        (clr),
    .frame_ack  (frameAck),
    .Q0         (Q0),
    .Q1         (Q1),
    .Q2         (Q2),
    .Q3         (Q3),
    .Q4         (Q4),
    .Q5         (Q5),
    .Q6         (Q6),
    .Q7         (Q7),
    .loaded     (loaded),
    .frame_done (frameDone),
    .ptr        (ptr)
  );

  assign qOut[0] = Q0;
  assign qOut[1] = Q1;
  assign qOut[2] = Q2;
  assign qOut[3] = Q3;
  assign qOut[4] = Q4;
  assign qOut[5] = Q5;
  assign qOut[6] = Q6;
  assign qOut[7] = Q7;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs, then advance to 1 time unit past the next rising edge
  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic [2:0] s,
                               input logic a, input logic c, input logic ack);
    inValid  = v;
    D        = d;
    S        = s;
    auto     = a;
    clr      = c;
    frameAck = ack;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] mQ [8];
  logic [7:0] mLoaded;
  int         mPtr;
  bit         mFull;
  int         mFrames;
  int         seenFrames;
  int         cycles;
  logic       expFd;
  logic       v;
  logic       ack;
  logic [3:0] d;

  initial begin
    rst = 1'b1; D = '0; S = '0; auto = 1'b0; inValid = 1'b0; clr = 1'b0; frameAck = 1'b0;
    #3;
    checkOutput("reset_loaded", 32'(loaded), 32'h0);
    checkOutput("reset_ptr", 32'(ptr), 32'h0);
    checkOutput("reset_fd", 32'(frameDone), 32'h0);
    checkOutput("reset_q0", 32'(Q0), 32'h0);
    #9 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("ready_after_reset", 32'(inReady), 32'h1);

    // Auto frame 1..8
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 4'(i + 1), 3'd0, 1'b1, 1'b0, 1'b0);
      if (i == 6) begin
        checkOutput("loaded_7", 32'(loaded), 32'h7F);
        checkOutput("fd_early", 32'(frameDone), 32'h0);
      end
    end
    checkOutput("fd_pulse", 32'(frameDone), 32'h1);
    checkOutput("loaded_full", 32'(loaded), 32'hFF);
    checkOutput("ptr_wrap", 32'(ptr), 32'h0);
    checkOutput("ready_full", 32'(inReady), 32'h0);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("frame1_q%0d", i), 32'(qOut[i]), 32'(i + 1));

    // Stall while FULL with a pending word
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'hA, 3'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("fd_one_cycle", 32'(frameDone), 32'h0);
    checkOutput("stall_q0", 32'(Q0), 32'h1);
    checkOutput("stall_ready", 32'(inReady), 32'h0);
    applyStimulus(1'b1, 4'hA, 3'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("ack_loaded", 32'(loaded), 32'h0);
    checkOutput("ack_ptr", 32'(ptr), 32'h0);
    checkOutput("ack_q7_kept", 32'(Q7), 32'h8);
    checkOutput("ack_ready", 32'(inReady), 32'h1);
    applyStimulus(1'b1, 4'hA, 3'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("held_word_q0", 32'(Q0), 32'hA);
    checkOutput("held_word_loaded", 32'(loaded), 32'h01);

    // Explicit mode with an overwrite
    applyStimulus(1'b0, 4'h0, 3'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("clr_loaded", 32'(loaded), 32'h0);
    checkOutput("clr_ptr", 32'(ptr), 32'h0);
    checkOutput("clr_q0_kept", 32'(Q0), 32'hA);
    applyStimulus(1'b1, 4'h3, 3'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("expl_q5_first", 32'(Q5), 32'h3);
    applyStimulus(1'b1, 4'h9, 3'd5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h4, 3'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("expl_q5", 32'(Q5), 32'h9);
    checkOutput("expl_q2", 32'(Q2), 32'h4);
    checkOutput("expl_loaded", 32'(loaded), 32'h24);
    checkOutput("expl_ptr", 32'(ptr), 32'h0);
    checkOutput("expl_fd", 32'(frameDone), 32'h0);

    // clr colliding with the 4th word of an auto frame
    applyStimulus(1'b0, 4'h0, 3'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'hB, 3'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hC, 3'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hD, 3'd0, 1'b1, 1'b0, 1'b0);
    inValid = 1'b1; D = 4'hE; clr = 1'b1;
    #1;
    checkOutput("clr_blocks_ready", 32'(inReady), 32'h0);
    applyStimulus(1'b1, 4'hE, 3'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("clr4_loaded", 32'(loaded), 32'h0);
    checkOutput("clr4_ptr", 32'(ptr), 32'h0);
    checkOutput("clr4_q3_kept", 32'(Q3), 32'h4);
    checkOutput("clr4_q0", 32'(Q0), 32'hB);
    checkOutput("clr4_q1", 32'(Q1), 32'hC);
    checkOutput("clr4_q2", 32'(Q2), 32'hD);
    checkOutput("clr4_fd", 32'(frameDone), 32'h0);

    // Asynchronous reset in the middle of a partial frame
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'(i + 5), 3'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("partial_loaded", 32'(loaded), 32'h0F);
    inValid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async_loaded", 32'(loaded), 32'h0);
    checkOutput("async_q0", 32'(Q0), 32'h0);
    checkOutput("async_q3", 32'(Q3), 32'h0);
    checkOutput("async_ptr", 32'(ptr), 32'h0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Random valid gaps over three auto frames, checked against a model
    for (int i = 0; i < 8; i++) mQ[i] = 4'h0;
    mLoaded = '0; mPtr = 0; mFull = 0; mFrames = 0; seenFrames = 0; cycles = 0;
    while (!(mFrames == 3 && !mFull) && cycles < 1000) begin
      v   = 1'($urandom_range(0, 1));
      ack = 1'($urandom_range(0, 1));
      d   = 4'($urandom);
      expFd = 1'b0;
      if (mFull && ack) begin
        mLoaded = '0; mPtr = 0; mFull = 0;
      end else if (v && !mFull) begin
        mQ[mPtr] = d;
        mLoaded[mPtr] = 1'b1;
        mPtr = (mPtr + 1) % 8;
        if (mLoaded == 8'hFF) begin
          mFull = 1; expFd = 1'b1; mFrames++;
        end
      end
      applyStimulus(v, d, 3'($urandom), 1'b1, 1'b0, ack);
      if (frameDone) seenFrames++;
      checkOutput("rand_loaded", 32'(loaded), 32'(mLoaded));
      checkOutput("rand_fd", 32'(frameDone), 32'(expFd));
      checkOutput("rand_ptr", 32'(ptr), 32'(mPtr));
      cycles++;
    end
    checkOutput("rand_within_budget", 32'(cycles < 1000), 32'h1);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("rand_q%0d", i), 32'(qOut[i]), 32'(mQ[i]));
    checkOutput("rand_frame_count", 32'(seenFrames), 32'd3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
